// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-requester memory arbiter: fetch port, data port and memory port.
// The arbiter attaches through the slave modport; the requester/memory environment uses master.
interface mem_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_valid;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          stall_i;
  logic          stall_d;
  logic          tmo_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_i, stall_d, tmo_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_i, stall_d, tmo_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, one transaction at a time,
// with round-robin on contention and a per-transaction ack timeout.
module mem_arbiter #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 32,
  parameter int unsigned TMO = 64
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int unsigned CW = $clog2(TMO);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t        state, stateNext;
  logic          lastGrantD;
  logic          served;
  logic [CW-1:0] tmoCnt;

  logic          iPend, dPend, done, grant;
  logic [AW-1:0] addrSel;
  logic [DW-1:0] wdataSel, rdataSel;
  logic          weSel;

  // A requester whose valid pulse is up is still holding its finished request; mask it.
  assign bus.stall_i = bus.i_req & ~bus.i_valid;
  assign bus.stall_d = bus.d_req & ~bus.d_valid;

  always_comb begin
    stateNext = state;
    iPend     = bus.i_req & ~bus.i_valid;
    dPend     = bus.d_req & ~bus.d_valid;
    done      = 1'b0;
    grant     = 1'b0;
    addrSel   = bus.i_addr;
    wdataSel  = '0;
    weSel     = 1'b0;
    rdataSel  = bus.mem_ack ? bus.mem_rdata : '0;
    case (state)
      IDLE: begin
        // Until something has completed since reset, contention favours the data port.
        if (dPend && (!iPend || !(served && lastGrantD))) begin
          stateNext = DBUSY;
          grant     = 1'b1;
          addrSel   = bus.d_addr;
          wdataSel  = bus.d_wdata;
          weSel     = bus.d_we;
        end else if (iPend) begin
          stateNext = IBUSY;
          grant     = 1'b1;
        end
      end
      IBUSY, DBUSY: begin
        done = bus.mem_ack | (tmoCnt == CW'(TMO - 1));
        if (done) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_valid   <= 1'b0;
      bus.d_valid   <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.tmo_err   <= 1'b0;
      lastGrantD    <= 1'b1;
      served        <= 1'b0;
      tmoCnt        <= '0;
    end else begin
      bus.i_valid <= 1'b0;
      bus.d_valid <= 1'b0;
      if (grant) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= weSel;
        bus.mem_addr  <= addrSel;
        bus.mem_wdata <= wdataSel;
        tmoCnt        <= '0;
      end else if (done) begin
        bus.mem_req <= 1'b0;
        lastGrantD  <= (state == DBUSY);
        served      <= 1'b1;
        if (!bus.mem_ack) bus.tmo_err <= 1'b1;
        if (state == IBUSY) begin
          bus.i_valid <= 1'b1;
          bus.i_rdata <= rdataSel;
        end else begin
          bus.d_valid <= 1'b1;
          if (!bus.mem_we) bus.d_rdata <= rdataSel;
        end
      end else if (state != IDLE) begin
        tmoCnt <= tmoCnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, fetch, contention, round-robin,
// timeout, ack-at-timeout boundary and reset mid-transaction.
module tb_mem_arbiter;
  localparam int unsigned TMO = 64;

  logic clk;
  logic reset;
  logic autoAck;
  logic manualAck;
  int   nChecks;
  int   nFail;

  mem_arbiter_if #(.DW(32), .AW(32)) bus ();

  mem_arbiter #(.DW(32), .AW(32), .TMO(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: either acks every cycle it is requested, or drives mem_ack from manualAck.
  always_comb bus.mem_ack = autoAck ? bus.mem_req : manualAck;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0;
    autoAck = 1'b0; manualAck = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    nChecks++;
    if ({bus.mem_req, bus.mem_we, bus.i_valid, bus.d_valid, bus.tmo_err} !== 5'b0) begin
      nFail++; $display("FAIL reset_ctrl: got %b expected 00000",
                        {bus.mem_req, bus.mem_we, bus.i_valid, bus.d_valid, bus.tmo_err});
    end
    nChecks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== 128'h0) begin
      nFail++; $display("FAIL reset_data: got %h expected 0",
                        {bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata});
    end
  endtask

  task automatic test_fetch();
    bus.i_req = 1'b1; bus.i_addr = 32'h100; bus.mem_rdata = 32'hE3A01005;
    cyc();
    nChecks++;
    if ({bus.mem_req, bus.mem_we, bus.stall_i} !== 3'b101 || bus.mem_addr !== 32'h100) begin
      nFail++; $display("FAIL fetch_grant: got req/we/stall %b addr %h expected 101 addr 00000100",
                        {bus.mem_req, bus.mem_we, bus.stall_i}, bus.mem_addr);
    end
    cyc(); cyc();
    nChecks++;
    if ({bus.mem_req, bus.mem_we, bus.i_valid} !== 3'b100) begin
      nFail++; $display("FAIL fetch_wait: got req/we/valid %b expected 100",
                        {bus.mem_req, bus.mem_we, bus.i_valid});
    end
    manualAck = 1'b1;
    cyc();
    nChecks++;
    if (bus.i_valid !== 1'b1 || bus.i_rdata !== 32'hE3A01005 || bus.stall_i !== 1'b0) begin
      nFail++; $display("FAIL fetch_done: got valid %b rdata %h stall %b expected 1 e3a01005 0",
                        bus.i_valid, bus.i_rdata, bus.stall_i);
    end
    bus.i_req = 1'b0; manualAck = 1'b0; bus.mem_rdata = 32'h0;
    cyc();
    nChecks++;
    if (bus.i_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.i_rdata !== 32'hE3A01005) begin
      nFail++; $display("FAIL fetch_after: got valid %b req %b rdata %h expected 0 0 e3a01005",
                        bus.i_valid, bus.mem_req, bus.i_rdata);
    end
  endtask

  task automatic test_contention();
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h64; bus.d_wdata = 32'h7;
    bus.mem_rdata = 32'h5555AAAA;
    autoAck = 1'b1;
    cyc();
    nChecks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h64 || bus.mem_wdata !== 32'h7) begin
      nFail++; $display("FAIL cont_dfirst: got we %b addr %h wdata %h expected 1 00000064 00000007",
                        bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    cyc();
    nChecks++;
    if ({bus.d_valid, bus.stall_d, bus.stall_i} !== 3'b101 || bus.d_rdata !== 32'h0) begin
      nFail++; $display("FAIL cont_dvalid: got valid/stall_d/stall_i %b rdata %h expected 101 0",
                        {bus.d_valid, bus.stall_d, bus.stall_i}, bus.d_rdata);
    end
    bus.d_req = 1'b0; bus.mem_rdata = 32'h12345678;
    cyc();
    nChecks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h200) begin
      nFail++; $display("FAIL cont_igrant: got req %b we %b addr %h expected 1 0 00000200",
                        bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    cyc();
    nChecks++;
    if (bus.i_valid !== 1'b1 || bus.i_rdata !== 32'h12345678) begin
      nFail++; $display("FAIL cont_ivalid: got valid %b rdata %h expected 1 12345678",
                        bus.i_valid, bus.i_rdata);
    end
    bus.i_req = 1'b0;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [31:0] expAddr [4];
    logic [31:0] data;
    expAddr[0] = 32'h300; expAddr[1] = 32'h400; expAddr[2] = 32'h300; expAddr[3] = 32'h400;
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    autoAck = 1'b1;
    for (int t = 0; t < 4; t++) begin
      data = 32'hA000_0000 + 32'(t);
      bus.mem_rdata = data;
      cyc();
      nChecks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== expAddr[t] || bus.stall_i !== 1'b1) begin
        nFail++; $display("FAIL rr_grant%0d: got req %b addr %h stall_i %b expected 1 %h 1",
                          t, bus.mem_req, bus.mem_addr, bus.stall_i, expAddr[t]);
      end
      cyc();
      if (t % 2 == 0) begin
        nChecks++;
        if (bus.d_valid !== 1'b1 || bus.i_valid !== 1'b0 || bus.d_rdata !== data) begin
          nFail++; $display("FAIL rr_done%0d: got d_valid %b i_valid %b d_rdata %h expected 1 0 %h",
                            t, bus.d_valid, bus.i_valid, bus.d_rdata, data);
        end
      end else begin
        nChecks++;
        if (bus.i_valid !== 1'b1 || bus.d_valid !== 1'b0 || bus.i_rdata !== data) begin
          nFail++; $display("FAIL rr_done%0d: got i_valid %b d_valid %b i_rdata %h expected 1 0 %h",
                            t, bus.i_valid, bus.d_valid, bus.i_rdata, data);
        end
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    cyc();
  endtask

  task automatic test_timeout();
    int n;
    autoAck = 1'b0; manualAck = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500; bus.mem_rdata = 32'hDEADBEEF;
    cyc();
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (bus.d_valid === 1'b1) break;
      if (bus.mem_req === 1'b1) n++;
      cyc();
    end
    nChecks++;
    if (bus.d_valid !== 1'b1 || n != TMO) begin
      nFail++; $display("FAIL tmo_cycles: got valid %b after %0d busy cycles expected 1 after %0d",
                        bus.d_valid, n, TMO);
    end
    nChecks++;
    if (bus.d_rdata !== 32'h0 || bus.tmo_err !== 1'b1) begin
      nFail++; $display("FAIL tmo_result: got rdata %h err %b expected 0 1", bus.d_rdata, bus.tmo_err);
    end
    bus.d_req = 1'b0;
    cyc();
    bus.i_req = 1'b1; bus.i_addr = 32'h600; autoAck = 1'b1;
    cyc(); cyc();
    bus.i_req = 1'b0; autoAck = 1'b0;
    cyc();
    nChecks++;
    if (bus.tmo_err !== 1'b1) begin
      nFail++; $display("FAIL tmo_sticky: got err %b expected 1", bus.tmo_err);
    end
  endtask

  task automatic test_reset_midop();
    bus.i_req = 1'b1; bus.i_addr = 32'h700; manualAck = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    nChecks++;
    if (bus.mem_req !== 1'b0 || bus.i_valid !== 1'b0 || bus.tmo_err !== 1'b0) begin
      nFail++; $display("FAIL midop_reset: got req %b valid %b err %b expected 0 0 0",
                        bus.mem_req, bus.i_valid, bus.tmo_err);
    end
    bus.i_req = 1'b0; reset = 1'b1;
    cyc();
    manualAck = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
    cyc(); cyc();
    nChecks++;
    if ({bus.i_valid, bus.d_valid, bus.mem_req} !== 3'b000 || bus.i_rdata !== 32'h0) begin
      nFail++; $display("FAIL spurious_ack: got valids/req %b i_rdata %h expected 000 0",
                        {bus.i_valid, bus.d_valid, bus.mem_req}, bus.i_rdata);
    end
    manualAck = 1'b0;
    cyc();
  endtask

  task automatic test_ack_at_timeout();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800; bus.mem_rdata = 32'h0000CAFE;
    cyc();
    for (int k = 0; k < TMO - 1; k++) cyc();
    nChecks++;
    if (bus.mem_req !== 1'b1 || bus.d_valid !== 1'b0) begin
      nFail++; $display("FAIL edge_wait: got req %b valid %b expected 1 0", bus.mem_req, bus.d_valid);
    end
    manualAck = 1'b1;
    cyc();
    nChecks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h0000CAFE || bus.tmo_err !== 1'b0) begin
      nFail++; $display("FAIL edge_ack: got valid %b rdata %h err %b expected 1 0000cafe 0",
                        bus.d_valid, bus.d_rdata, bus.tmo_err);
    end
    manualAck = 1'b0; bus.d_req = 1'b0;
    cyc();
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    reset   = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_contention();
    test_round_robin();
    test_timeout();
    test_reset_midop();
    test_ack_at_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DW, 32, data width of both requester ports and the memory port.
REQ-002 Parameter: AW, 32, address width.
REQ-003 Parameter: TMO, 64, max cycles to wait for mem_ack before timeout; TMO >= 2.
REQ-004 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset (0 = reset on next rising clk edge).
REQ-006 Ports: i_req in 1, fetch request; i_addr in AW, fetch address.
REQ-007 Ports: i_rdata out DW, fetched word; i_valid out 1, one-cycle completion pulse.
REQ-008 Ports: d_req in 1, data request; d_we in 1, 1 = write; d_addr in AW; d_wdata in DW.
REQ-009 Ports: d_rdata out DW, load data; d_valid out 1, one-cycle completion pulse.
REQ-010 Ports: mem_req out 1; mem_we out 1; mem_addr out AW; mem_wdata out DW; mem_rdata in DW; mem_ack in 1, transaction done, mem_rdata valid when read.
REQ-011 Ports: stall_i out 1, fetch port must hold; stall_d out 1, data port must hold; tmo_err out 1, sticky timeout flag.

Function
REQ-012 FSM states: IDLE, IBUSY, DBUSY.
REQ-013 IDLE: mem_req=0; picks a grant from i_req/d_req sampled at the edge.
REQ-014 Arbitration: d_req alone -> DBUSY; i_req alone -> IBUSY; both -> DBUSY unless last_grant=D, then IBUSY (round-robin on contention only).
REQ-015 last_grant is updated only when a transaction completes.
REQ-016 Busy states: mem_req=1; mem_addr/mem_we/mem_wdata are registered at grant and held stable until completion.
REQ-017 mem_we=0 in IBUSY; mem_we=d_we (captured) in DBUSY.
REQ-018 Completion: mem_ack=1 in a busy state -> next cycle: owner valid=1 for exactly 1 cycle, owner rdata=mem_rdata (captured), state=IDLE.
REQ-019 Completion is single-cycle minimum: grant edge N, mem_ack at N+1 -> valid at N+2.
REQ-020 Writes: d_valid also pulses; d_rdata is unchanged by writes.
REQ-021 i_rdata/d_rdata hold their last value between completions.
REQ-022 stall_i = i_req & ~i_valid (combinational); stall_d = d_req & ~d_valid.
REQ-023 Requesters hold req/addr/data stable until their valid pulse; arbiter does not re-sample a held request while serving it.
REQ-024 In the valid cycle the state is IDLE and a new request may be granted the same edge (back-to-back throughput: one transaction per 2 cycles minimum).
REQ-025 Timeout counter: cleared at grant, increments each busy cycle without mem_ack.
REQ-026 Counter reaching TMO-1 with no mem_ack: complete as REQ-018 with rdata=0, set tmo_err=1.
REQ-027 tmo_err is cleared only by reset.
REQ-028 mem_ack in IDLE (late or spurious) is ignored; no valid pulse, no state change.
REQ-029 mem_ack and timeout in the same cycle: treat as normal ack, tmo_err unchanged.

Reset
REQ-030 reset=0 at an edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_valid=0, d_valid=0, i_rdata=0, d_rdata=0, tmo_err=0, last_grant=D, counter=0.
REQ-031 Reset mid-transaction abandons it: no valid pulse; mem_req low in the cycle after the reset edge.

Verification
REQ-032 Fetch only: i_req=1, i_addr=0x100, mem_ack after 3 busy cycles with rdata=0xE3A01005 -> i_valid one pulse, i_rdata=0xE3A01005, mem_we=0 throughout.
REQ-033 Contention from reset: i_req=d_req=1 (d_we=1, d_addr=0x64, d_wdata=0x7) -> data served first with mem_we=1, mem_addr=0x64; fetch granted the edge of d_valid.
REQ-034 Round-robin: both held requesting for 4 transactions, 1-cycle ack -> grant order D,I,D,I; stall_i high until each i_valid.
REQ-035 Timeout: d_req read, mem_ack never -> d_valid after TMO busy cycles, d_rdata=0, tmo_err=1 and stays 1 until reset.
REQ-036 Reset mid-op: reset=0 while in IBUSY -> no i_valid, mem_req=0 next cycle; later spurious mem_ack ignored.
